// File: rtl/seq_multiplier_if.sv
// Operand/result handshake bundle for seq_multiplier: valid/ready in, valid/ready out.
interface seq_multiplier_if #(
  parameter int WIDTH = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               in_signed;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_product;

  modport master (
    output in_valid, in_a, in_b, in_signed, out_ready,
    input  in_ready, out_valid, out_product
  );

  modport slave (
    input  in_valid, in_a, in_b, in_signed, out_ready,
    output in_ready, out_valid, out_product
  );
endinterface

// File: rtl/seq_multiplier.sv
// Multi-cycle shift-add multiplier: STEP multiplier bits per clock on unsigned magnitudes,
// sign applied once at the end. Valid/ready on both sides, back-to-back accept from DONE.
module seq_multiplier #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  seq_multiplier_if.slave bus
);
  localparam int N  = WIDTH / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * WIDTH;
  localparam int SW = $clog2(PW) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [PW-1:0]    acc, acc_next, pp, product;
  logic             neg;
  logic [CW-1:0]    count;
  logic [SW-1:0]    shamt;
  logic             accept, last;

  // Partial product of the full multiplicand with the low STEP bits of the shrinking multiplier.
  always_comb begin
    shamt    = SW'(count) * SW'(STEP);
    pp       = ({{WIDTH{1'b0}}, mag_a} * {{(PW-STEP){1'b0}}, mag_b[STEP-1:0]}) << shamt;
    acc_next = acc + pp;
    last     = (count == CW'(N - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next    = state;
    bus.in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
    bus.out_valid = (state == DONE);
    accept        = bus.in_valid && bus.in_ready;
    case (state)
      IDLE:    if (accept) state_next = BUSY;
      BUSY:    if (last) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = accept ? BUSY : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mag_a   <= '0;
      mag_b   <= '0;
      neg     <= 1'b0;
      acc     <= '0;
      count   <= '0;
      product <= '0;
    end else if (accept) begin
      // -2^(WIDTH-1) negates to itself, which is exactly its unsigned magnitude.
      mag_a <= (bus.in_signed && bus.in_a[WIDTH-1]) ? -bus.in_a : bus.in_a;
      mag_b <= (bus.in_signed && bus.in_b[WIDTH-1]) ? -bus.in_b : bus.in_b;
      neg   <= bus.in_signed && (bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1]);
      acc   <= '0;
      count <= '0;
    end else if (state == BUSY) begin
      acc   <= acc_next;
      mag_b <= mag_b >> STEP;
      count <= count + 1'b1;
      if (last) product <= neg ? -acc_next : acc_next;
    end
  end

  assign bus.out_product = product;
endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench: directed corner cases and random traffic on a 32/4 and an 8/2 instance.
module tb_seq_multiplier;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_multiplier_if #(.WIDTH(32)) m();
  seq_multiplier_if #(.WIDTH(8))  s();

  seq_multiplier #(.WIDTH(32), .STEP(4)) dut   (.clk(clk), .rst_n(rst_n), .bus(m));
  seq_multiplier #(.WIDTH(8),  .STEP(2)) dut8  (.clk(clk), .rst_n(rst_n), .bus(s));

  typedef struct {
    logic [63:0] p;
    int          t;
  } exp_t;

  exp_t q[$];
  exp_t q8[$];
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: sign/zero-extend to 64 bits, multiply, keep the low 2*w bits.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input bit sg, input int w);
    logic [63:0] ax, bx, r;
    ax = {32'd0, a};
    bx = {32'd0, b};
    if (sg && a[w-1]) ax = ax | (~64'd0 << w);
    if (sg && b[w-1]) bx = bx | (~64'd0 << w);
    r = ax * bx;
    if (w < 32) r = r & ((64'd1 << (2 * w)) - 64'd1);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // ---------------- monitors ----------------
  exp_t cur, cur8;
  bit   pv = 1'b0, pv8 = 1'b0;

  always @(negedge clk) begin
    if (rst_n && m.out_valid) begin
      if (!pv) begin
        if (q.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL unexpected_result32: got %h expected none", m.out_product);
          cur.p = m.out_product; cur.t = cyc;
        end else begin
          cur = q.pop_front();
          chk("product32", m.out_product, cur.p);
          chk("latency32", 64'(cyc - cur.t), 64'd8);
        end
      end else chk("held32", m.out_product, cur.p);
    end
    pv = rst_n && m.out_valid;
  end

  always @(negedge clk) begin
    if (rst_n && s.out_valid) begin
      if (!pv8) begin
        if (q8.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL unexpected_result8: got %h expected none", s.out_product);
          cur8.p = 64'(s.out_product); cur8.t = cyc;
        end else begin
          cur8 = q8.pop_front();
          chk("product8", 64'(s.out_product), cur8.p);
          chk("latency8", 64'(cyc - cur8.t), 64'd4);
        end
      end else chk("held8", 64'(s.out_product), cur8.p);
    end
    pv8 = rst_n && s.out_valid;
  end

  // ---------------- 32-bit drivers ----------------
  // om: 0/1 fixed out_ready, 2 random
  task automatic tick(input bit v, input logic [31:0] a, input logic [31:0] b, input bit sg,
                      input int om, output bit acc);
    @(negedge clk);
    m.in_valid  = v;
    m.in_a      = a;
    m.in_b      = b;
    m.in_signed = sg;
    m.out_ready = (om == 2) ? 1'($urandom_range(0, 1)) : 1'(om);
    #1;
    acc = v && m.in_ready;
    if (m.out_valid && !m.out_ready) chk("in_ready_blocked32", 64'(m.in_ready), 64'd0);
    if (acc) q.push_back('{p: model(a, b, sg, 32), t: cyc + 1});
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input bit sg, input int om);
    bit acc;
    int n = 0;
    do begin tick(1'b1, a, b, sg, om, acc); n++; end while (!acc && n < 200);
    if (!acc) begin compared++; mismatched++; $display("FAIL accept_timeout32: got none expected accept"); end
  endtask

  task automatic drain(input int om);
    bit acc;
    int n = 0;
    while ((q.size() > 0 || m.out_valid) && n < 500) begin tick(1'b0, 0, 0, 1'b0, om, acc); n++; end
    if (n >= 500) begin compared++; mismatched++; $display("FAIL drain_timeout32: got %0d pending expected 0", q.size()); end
  endtask

  // ---------------- 8-bit drivers ----------------
  task automatic tick8(input bit v, input logic [7:0] a, input logic [7:0] b, input bit sg,
                       input int om, output bit acc);
    @(negedge clk);
    s.in_valid  = v;
    s.in_a      = a;
    s.in_b      = b;
    s.in_signed = sg;
    s.out_ready = (om == 2) ? 1'($urandom_range(0, 1)) : 1'(om);
    #1;
    acc = v && s.in_ready;
    if (s.out_valid && !s.out_ready) chk("in_ready_blocked8", 64'(s.in_ready), 64'd0);
    if (acc) q8.push_back('{p: model({24'd0, a}, {24'd0, b}, sg, 8), t: cyc + 1});
  endtask

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input bit sg, input int om);
    bit acc;
    int n = 0;
    do begin tick8(1'b1, a, b, sg, om, acc); n++; end while (!acc && n < 200);
    if (!acc) begin compared++; mismatched++; $display("FAIL accept_timeout8: got none expected accept"); end
  endtask

  task automatic drain8();
    bit acc;
    int n = 0;
    while ((q8.size() > 0 || s.out_valid) && n < 500) begin tick8(1'b0, 0, 0, 1'b0, 1, acc); n++; end
    if (n >= 500) begin compared++; mismatched++; $display("FAIL drain_timeout8: got %0d pending expected 0", q8.size()); end
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit acc;
    int n;
    m.in_valid = 0; m.in_a = 0; m.in_b = 0; m.in_signed = 0; m.out_ready = 0;
    s.in_valid = 0; s.in_a = 0; s.in_b = 0; s.in_signed = 0; s.out_ready = 0;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(m.out_valid), 64'd0);
    chk("rst_out_product", m.out_product, 64'd0);
    chk("rst_in_ready", 64'(m.in_ready), 64'd1);
    chk("rst_out_valid8", 64'(s.out_valid), 64'd0);
    chk("rst_in_ready8", 64'(s.in_ready), 64'd1);
    rst_n = 1'b1;

    // directed corners
    send(32'hFFFF_FFFD, 32'd7, 1'b1, 1);          drain(1);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1);  drain(1);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1);  drain(1);
    send(32'h8000_0000, 32'h8000_0000, 1'b1, 1);  drain(1);
    send(32'h8000_0000, 32'd1, 1'b1, 1);          drain(1);
    send(32'd0, 32'hFFFF_FFFF, 1'b1, 1);          drain(1);

    // held result with out_ready low, then back-to-back accept on retirement
    send(32'd123, 32'd456, 1'b0, 0);
    n = 0;
    while (!m.out_valid && n < 50) begin tick(1'b0, 0, 0, 1'b0, 0, acc); n++; end
    chk("done_reached", 64'(m.out_valid), 64'd1);
    repeat (5) begin
      tick(1'b1, 32'd5, 32'd6, 1'b0, 0, acc);
      chk("no_accept_while_held", 64'(acc), 64'd0);
    end
    tick(1'b1, 32'd5, 32'd6, 1'b0, 1, acc);
    chk("accept_on_retire", 64'(acc), 64'd1);
    drain(1);

    // reset on the 4th busy edge aborts the operation
    send(32'd1000, 32'd77, 1'b0, 1);
    m.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort_out_valid", 64'(m.out_valid), 64'd0);
    chk("abort_in_ready", 64'(m.in_ready), 64'd1);
    chk("abort_out_product", m.out_product, 64'd0);
    repeat (12) tick(1'b0, 0, 0, 1'b0, 1, acc);

    // random 32-bit traffic with random backpressure
    repeat (300) begin
      send(rnd32(), rnd32(), 1'($urandom_range(0, 1)), 2);
      if ($urandom_range(0, 3) == 0) tick(1'b0, 0, 0, 1'b0, 2, acc);
    end
    drain(1);

    // 8-bit / step-2 instance: random sample of the operand space, both modes
    send8(8'h80, 8'h80, 1'b1, 1);
    send8(8'hFF, 8'hFF, 1'b0, 1);
    send8(8'hFF, 8'h01, 1'b1, 1);
    repeat (2500) send8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 2);
    drain8();

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
